traffic_ctrl_param: RTL and testbench
=====================================

# traffic_ctrl_param

Parametrised two-road intersection controller: south (s) and west (w) approaches, each with a red/yellow/green head.
- Sequence: fixed green → yellow → all-red rotation for each road, with per-phase durations set by parameters and counted in ticks of an external time-base strobe.
- Added behaviours: a latched pedestrian request that shortens the running green, a night/flash mode, and a countdown output for a display.
- Position: sits beneath the board top level, after the tick divider.

## Interface
Parameters:
- CNT_W, 8, countdown/counter width
- GREEN_S, 20, south green duration in ticks
- GREEN_W, 20, west green duration in ticks
- YELLOW, 3, yellow duration in ticks (both roads)
- ALLRED, 2, all-red clearance duration in ticks
- PED_MIN, 3, minimum remaining green ticks after a pedestrian request

Parameter legality:
- All durations are ≥1 and ≤2^CNT_W.
- PED_MIN < GREEN_S and PED_MIN < GREEN_W.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle time-base strobe; all timing advances only on cycles with tick=1
- ped_req  in  1  pedestrian button, sampled every clk
- flash_req  in  1  level; night/flash mode request
- light_s  out  3  south head: 3'b100 green, 3'b010 yellow, 3'b001 red, 3'b000 dark
- light_w  out  3  west head, same encoding
- remain  out  CNT_W  ticks left in current phase minus one
- state  out  3  current FSM state code
- ped_ack  out  1  one-cycle pulse when a pending pedestrian request is served

## Operation
State codes:
- S_GRN=0, S_YEL=1, RED_A=2, W_GRN=3, W_YEL=4, RED_B=5, FLASH=6.
- Code 7 is illegal and recovers to RED_B with remain=ALLRED-1 at the next clk.

Phase rotation (on tick with remain==0):
- S_GRN→S_YEL, S_YEL→RED_A, RED_A→W_GRN, W_GRN→W_YEL, W_YEL→RED_B, RED_B→S_GRN.
- On every transition, remain loads the new phase duration minus one.
- On a tick with remain≠0, remain decrements by 1.
- Without tick, state and remain hold.

Lights (pure decode of state):
- S_GRN: s=100, w=001.
- S_YEL: s=010, w=001.
- RED_A, RED_B: both 001.
- W_GRN: s=001, w=100.
- W_YEL: s=001, w=010.
- FLASH: both 010 when blink=1, both 000 when blink=0.

Pedestrian request:
- Setting: ped_req=1 on any clk sets ped_pend.
- Shortening: in S_GRN or W_GRN, on a tick with ped_pend=1 and remain>PED_MIN, remain loads PED_MIN instead of decrementing. Otherwise normal decrement applies.
- Serving: on entry to RED_A or RED_B, if ped_pend=1, then ped_pend clears and ped_ack pulses for exactly one clk (the cycle the new state is first visible).
- A ped_req in the same clk as that entry keeps ped_pend set (set wins).
- A request raised during yellow or all-red waits for the next green, which is shortened.

Flash mode:
- Entry: flash_req is examined only on the tick ending RED_A or RED_B (remain==0). If 1, next state is FLASH, remain=0, blink=1.
- While in FLASH, blink toggles on every tick and remain holds 0.
- Exit: on a tick with flash_req=0, go to RED_B with remain=ALLRED-1; the normal S_GRN start follows.
- A flash_req change mid-green does nothing until the next all-red end.
- ped_pend is held (not served) in FLASH.

## Timing
- Single clock domain; all state, remain, blink, ped_pend and ped_ack are registered. Lights are a combinational decode of registered state.
- Each non-flash phase lasts exactly duration ticks (e.g. YELLOW=3 → three ticks).
- A transition becomes visible on outputs the clk after the terminating tick cycle.
- Reset (asynchronous assert, synchronous-to-clk deassert by the system):
  - state=S_GRN, remain=GREEN_S-1
  - light_s=100, light_w=001
  - ped_pend=0, ped_ack=0, blink=0
- Reset mid-phase or in FLASH: immediate return to the reset values; pending requests are lost.
- tick and ped_req both high in the same cycle during green: ped_pend is set that edge; shortening applies from the next tick onward.
- remain arithmetic is unsigned CNT_W bits and never wraps; it never decrements below 0.

## Test plan
- Reset then tick every clk, GREEN_S=5, GREEN_W=4, YELLOW=2, ALLRED=1: states S_GRN×5, S_YEL×2, RED_A×1, W_GRN×4, W_YEL×2, RED_B×1 clks, then repeat. light_s/light_w match the decode each cycle.
- tick every 4th clk: each phase lasts 4× the clk counts above. remain holds between ticks.
- Defaults, ped_req pulse at S_GRN remain=15: next tick remain=3, so 4 more green ticks. ped_ack=1 for exactly one clk on RED_A entry. The following W_GRN runs a full 20 ticks.
- ped_req during S_YEL: S_YEL is unchanged. W_GRN is shortened to PED_MIN+1 ticks after its first tick; ped_ack fires at RED_B entry.
- flash_req=1 raised during W_GRN: no effect until RED_B ends, then FLASH with lights alternating 010/000 per tick. Drop flash_req → RED_B for ALLRED ticks, then S_GRN with remain=GREEN_S-1.
- Assert rst low mid-W_YEL, and separately mid-FLASH: outputs go to reset values that same cycle. After release, normal S_GRN operation resumes.

Source files
------------

// File: rtl/traffic_ctrl_param_if.sv
// rtl/traffic_ctrl_param_if.sv - control and display bundle of the intersection controller
// master drives the strobes and requests; slave (the controller) drives lights and status.
`timescale 1ns/1ps
interface traffic_ctrl_param_if #(
  parameter int CNT_W = 8
);
  logic             tick;
  logic             ped_req;
  logic             flash_req;
  logic [2:0]       light_s;
  logic [2:0]       light_w;
  logic [CNT_W-1:0] remain;
  logic [2:0]       state;
  logic             ped_ack;

  modport master (
    output tick, ped_req, flash_req,
    input  light_s, light_w, remain, state, ped_ack
  );

  modport slave (
    input  tick, ped_req, flash_req,
    output light_s, light_w, remain, state, ped_ack
  );
endinterface

// File: rtl/traffic_ctrl_param.sv
// rtl/traffic_ctrl_param.sv - two-road traffic light controller with ped request and flash mode
// Phases advance on tick strobes; lights are a decode of the registered state.
`timescale 1ns/1ps
module traffic_ctrl_param #(
  parameter int CNT_W   = 8,
  parameter int GREEN_S = 20,
  parameter int GREEN_W = 20,
  parameter int YELLOW  = 3,
  parameter int ALLRED  = 2,
  parameter int PED_MIN = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  traffic_ctrl_param_if.slave  bus
);

  typedef enum logic [2:0] {
    S_GRN = 3'd0,
    S_YEL = 3'd1,
    RED_A = 3'd2,
    W_GRN = 3'd3,
    W_YEL = 3'd4,
    RED_B = 3'd5,
    FLASH = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] GS_M1 = CNT_W'(GREEN_S - 1);
  localparam logic [CNT_W-1:0] GW_M1 = CNT_W'(GREEN_W - 1);
  localparam logic [CNT_W-1:0] Y_M1  = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_M1 = CNT_W'(ALLRED - 1);
  localparam logic [CNT_W-1:0] PM    = CNT_W'(PED_MIN);

  state_t           st;
  logic [CNT_W-1:0] rem;
  logic             blink;
  logic             ped_pend;
  logic             ped_armed;
  logic             ped_ack_r;

  // ped_armed marks a request that was pending while a green ran; only such a
  // request is served at the following all-red, later ones wait for the next green.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= S_GRN;
      rem       <= GS_M1;
      blink     <= 1'b0;
      ped_pend  <= 1'b0;
      ped_armed <= 1'b0;
      ped_ack_r <= 1'b0;
    end else begin
      ped_ack_r <= 1'b0;
      if (bus.ped_req) ped_pend <= 1'b1;
      if ((st == S_GRN || st == W_GRN) && ped_pend) ped_armed <= 1'b1;
      case (st)
        S_GRN, W_GRN: begin
          if (bus.tick) begin
            if (rem == '0) begin
              st  <= (st == S_GRN) ? S_YEL : W_YEL;
              rem <= Y_M1;
            end else if (ped_pend && rem > PM) begin
              rem <= PM;
            end else begin
              rem <= rem - 1'b1;
            end
          end
        end
        S_YEL, W_YEL: begin
          if (bus.tick) begin
            if (rem == '0) begin
              st  <= (st == S_YEL) ? RED_A : RED_B;
              rem <= AR_M1;
              if (ped_armed) begin
                ped_ack_r <= 1'b1;
                ped_pend  <= bus.ped_req;
                ped_armed <= 1'b0;
              end
            end else begin
              rem <= rem - 1'b1;
            end
          end
        end
        RED_A, RED_B: begin
          if (bus.tick) begin
            if (rem == '0) begin
              if (bus.flash_req) begin
                st    <= FLASH;
                rem   <= '0;
                blink <= 1'b1;
              end else if (st == RED_A) begin
                st  <= W_GRN;
                rem <= GW_M1;
              end else begin
                st  <= S_GRN;
                rem <= GS_M1;
              end
            end else begin
              rem <= rem - 1'b1;
            end
          end
        end
        FLASH: begin
          if (bus.tick) begin
            if (!bus.flash_req) begin
              st    <= RED_B;
              rem   <= AR_M1;
              blink <= 1'b0;
            end else begin
              blink <= ~blink;
            end
          end
        end
        default: begin
          st  <= RED_B;
          rem <= AR_M1;
        end
      endcase
    end
  end

  always_comb begin
    bus.light_s = 3'b001;
    bus.light_w = 3'b001;
    case (st)
      S_GRN: bus.light_s = 3'b100;
      S_YEL: bus.light_s = 3'b010;
      W_GRN: bus.light_w = 3'b100;
      W_YEL: bus.light_w = 3'b010;
      FLASH: begin
        bus.light_s = blink ? 3'b010 : 3'b000;
        bus.light_w = blink ? 3'b010 : 3'b000;
      end
      default: ;
    endcase
  end

  assign bus.remain  = rem;
  assign bus.state   = st;
  assign bus.ped_ack = ped_ack_r;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// tb/tb_traffic_ctrl_param.sv - directed bench for traffic_ctrl_param
// Small durations: GREEN_S=5, GREEN_W=4, YELLOW=2, ALLRED=1, PED_MIN=1.
`timescale 1ns/1ps
module tb_traffic_ctrl_param;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  traffic_ctrl_param_if #(.CNT_W(8)) bus ();

  traffic_ctrl_param #(
    .CNT_W(8), .GREEN_S(5), .GREEN_W(4), .YELLOW(2), .ALLRED(1), .PED_MIN(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int         dur [6] = '{5, 2, 1, 4, 2, 1};
  logic [2:0] ls  [6] = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b001, 3'b001};
  logic [2:0] lw  [6] = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b010, 3'b001};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [2:0] s, input logic [7:0] r,
                         input logic [2:0] l_s, input logic [2:0] l_w);
    chk({tag, ".state"}, 32'(bus.state), 32'(s));
    chk({tag, ".remain"}, 32'(bus.remain), 32'(r));
    chk({tag, ".light_s"}, 32'(bus.light_s), 32'(l_s));
    chk({tag, ".light_w"}, 32'(bus.light_w), 32'(l_w));
  endtask

  task automatic run_to(input logic [2:0] s, input logic [7:0] r);
    int k;
    k = 0;
    while (!(bus.state == s && bus.remain == r) && k < 200) begin
      cyc();
      k++;
    end
    chk("run_to_reached", 32'(k < 200), 32'd1);
  endtask

  initial begin
    bus.tick = 1'b0;
    bus.ped_req = 1'b0;
    bus.flash_req = 1'b0;
    cyc();
    cyc();
    chk_out("reset", 3'd0, 8'd4, 3'b100, 3'b001);
    chk("reset.ped_ack", 32'(bus.ped_ack), 32'd0);

    // tick every clk, two full rotations
    rst = 1'b1;
    bus.tick = 1'b1;
    for (int rot = 0; rot < 2; rot++)
      for (int p = 0; p < 6; p++)
        for (int k = 0; k < dur[p]; k++) begin
          chk_out("rot1", 3'(p), 8'(dur[p] - 1 - k), ls[p], lw[p]);
          cyc();
        end

    // tick every 4th clk: remain holds between ticks
    for (int p = 0; p < 6; p++)
      for (int k = 0; k < dur[p]; k++)
        for (int j = 0; j < 4; j++) begin
          bus.tick = (j == 3);
          chk("rot4.state", 32'(bus.state), 32'(p));
          chk("rot4.remain", 32'(bus.remain), 32'(dur[p] - 1 - k));
          cyc();
        end

    // ped request in S_GRN at remain=4 with a tick in the same cycle
    bus.tick = 1'b1;
    bus.ped_req = 1'b1;
    cyc();
    bus.ped_req = 1'b0;
    chk("ped.first_dec", 32'(bus.remain), 32'd3);
    cyc();
    chk("ped.shortened", 32'(bus.remain), 32'd1);
    cyc();
    cyc();
    chk_out("ped.syel", 3'd1, 8'd1, 3'b010, 3'b001);
    cyc();
    cyc();
    chk("ped.reda_state", 32'(bus.state), 32'd2);
    chk("ped.ack_reda", 32'(bus.ped_ack), 32'd1);
    cyc();
    chk("ped.ack_gone", 32'(bus.ped_ack), 32'd0);
    chk_out("ped.wgrn_full", 3'd3, 8'd3, 3'b001, 3'b100);
    cyc();
    chk("ped.wgrn_dec", 32'(bus.remain), 32'd2);

    // ped request during S_YEL waits for W_GRN
    run_to(3'd1, 8'd1);
    bus.ped_req = 1'b1;
    cyc();
    bus.ped_req = 1'b0;
    chk_out("pedy.syel", 3'd1, 8'd0, 3'b010, 3'b001);
    cyc();
    chk("pedy.reda_state", 32'(bus.state), 32'd2);
    chk("pedy.no_ack_reda", 32'(bus.ped_ack), 32'd0);
    cyc();
    chk_out("pedy.wgrn", 3'd3, 8'd3, 3'b001, 3'b100);
    cyc();
    chk("pedy.wgrn_short", 32'(bus.remain), 32'd1);
    cyc();
    cyc();
    chk_out("pedy.wyel", 3'd4, 8'd1, 3'b001, 3'b010);
    cyc();
    cyc();
    chk_out("pedy.redb", 3'd5, 8'd0, 3'b001, 3'b001);
    chk("pedy.ack_redb", 32'(bus.ped_ack), 32'd1);
    cyc();
    chk_out("pedy.sgrn", 3'd0, 8'd4, 3'b100, 3'b001);
    chk("pedy.ack_gone", 32'(bus.ped_ack), 32'd0);

    // flash request raised mid W_GRN takes effect at RED_B end
    run_to(3'd3, 8'd2);
    bus.flash_req = 1'b1;
    cyc();
    cyc();
    cyc();
    chk_out("fl.wyel", 3'd4, 8'd1, 3'b001, 3'b010);
    cyc();
    cyc();
    chk_out("fl.redb", 3'd5, 8'd0, 3'b001, 3'b001);
    cyc();
    chk_out("fl.on", 3'd6, 8'd0, 3'b010, 3'b010);
    cyc();
    chk_out("fl.dark", 3'd6, 8'd0, 3'b000, 3'b000);
    bus.tick = 1'b0;
    cyc();
    chk_out("fl.hold", 3'd6, 8'd0, 3'b000, 3'b000);
    bus.tick = 1'b1;
    cyc();
    chk_out("fl.on2", 3'd6, 8'd0, 3'b010, 3'b010);
    bus.flash_req = 1'b0;
    cyc();
    chk_out("fl.exit_redb", 3'd5, 8'd0, 3'b001, 3'b001);
    cyc();
    chk_out("fl.sgrn", 3'd0, 8'd4, 3'b100, 3'b001);

    // asynchronous reset mid W_YEL
    run_to(3'd4, 8'd1);
    rst = 1'b0;
    #1;
    chk_out("rst_wyel", 3'd0, 8'd4, 3'b100, 3'b001);
    cyc();
    rst = 1'b1;
    cyc();
    chk_out("rst_wyel.resume", 3'd0, 8'd3, 3'b100, 3'b001);

    // asynchronous reset mid FLASH
    bus.flash_req = 1'b1;
    run_to(3'd6, 8'd0);
    rst = 1'b0;
    #1;
    chk_out("rst_flash", 3'd0, 8'd4, 3'b100, 3'b001);
    bus.flash_req = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    chk_out("rst_flash.resume", 3'd0, 8'd3, 3'b100, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
